// File: rtl/equation2_gen_if.sv
// equation2_gen_if: start request, timer input and result handshake of the
// equation-2 puzzle generator. The master modport is the generator side,
// the slave modport is the requesting / consuming side.
interface equation2_gen_if;
  logic       startEq2;
  logic [6:0] OngoingTimer;
  logic       ready;
  logic       valid;
  logic       busy;
  logic       noSolution;
  logic [7:0] solX;
  logic [7:0] solY;
  logic [7:0] solZ;
  logic [7:0] target;

  modport master (
    input  startEq2, OngoingTimer, ready,
    output valid, busy, noSolution, solX, solY, solZ, target
  );

  modport slave (
    output startEq2, OngoingTimer, ready,
    input  valid, busy, noSolution, solX, solY, solZ, target
  );
endinterface

// File: rtl/equation2_gen.sv
// equation2_gen: latches the timer as an 8-bit target and searches the
// triples (x, y, z) with x in 1..MAX_VAL and y, z in their minimum..MAX_VAL,
// z fastest, for x*x*z + x*y == target (mod 256). Each candidate takes three
// cycles (x*x, then *z and x*y, then compare). The result, or a no-solution
// indication, is presented on a valid/ready handshake.
// Build option: define EQ2GEN_SKIP_TRIVIAL_EN to start y and z at 1 instead
// of 0, so every variable of the generated puzzle is nonzero.
module equation2_gen #(
  parameter int unsigned MAX_VAL = 15
) (
  input logic            Clock,
  input logic            Reset,
  equation2_gen_if.master bus
);

  localparam logic [7:0] MAX_V = MAX_VAL[7:0];
`ifdef EQ2GEN_SKIP_TRIVIAL_EN
  localparam logic [7:0] YMIN = 8'd1;
  localparam logic [7:0] ZMIN = 8'd1;
`else
  localparam logic [7:0] YMIN = 8'd0;
  localparam logic [7:0] ZMIN = 8'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EVAL_XX  = 3'd1,
    S_EVAL_XXZ = 3'd2,
    S_CHECK    = 3'd3,
    S_PRESENT  = 3'd4,
    S_FAIL     = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] z_q, z_d;
  logic [7:0] t1_q, t1_d;
  logic [7:0] t2_q, t2_d;
  logic [7:0] target_q, target_d;
  logic [7:0] sol_x_q, sol_x_d;
  logic [7:0] sol_y_q, sol_y_d;
  logic [7:0] sol_z_q, sol_z_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       no_sol_q, no_sol_d;

  // Full-width products; only the low byte is kept, giving mod-256 wrap.
  logic [15:0] xx_prod_s;
  logic [15:0] xxz_prod_s;
  logic [15:0] xy_prod_s;
  logic [7:0]  sum_s;
  logic        last_s;

  assign xx_prod_s  = {8'd0, x_q}  * {8'd0, x_q};
  assign xxz_prod_s = {8'd0, t1_q} * {8'd0, z_q};
  assign xy_prod_s  = {8'd0, x_q}  * {8'd0, y_q};
  assign sum_s      = t1_q + t2_q;
  assign last_s     = (x_q == MAX_V) && (y_q == MAX_V) && (z_q == MAX_V);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    target_d = target_q;
    sol_x_d  = sol_x_q;
    sol_y_d  = sol_y_q;
    sol_z_d  = sol_z_q;

    case (state_q)
      S_IDLE: begin
        if (bus.startEq2) begin
          target_d = {1'b0, bus.OngoingTimer};
          x_d      = 8'd1;
          y_d      = YMIN;
          z_d      = ZMIN;
          state_d  = S_EVAL_XX;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EVAL_XX: begin
        t1_d    = xx_prod_s[7:0];
        state_d = S_EVAL_XXZ;
      end
      S_EVAL_XXZ: begin
        t1_d    = xxz_prod_s[7:0];
        t2_d    = xy_prod_s[7:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (sum_s == target_q) begin
          sol_x_d = x_q;
          sol_y_d = y_q;
          sol_z_d = z_q;
          state_d = S_PRESENT;
        end else if (last_s) begin
          sol_x_d = 8'd0;
          sol_y_d = 8'd0;
          sol_z_d = 8'd0;
          state_d = S_FAIL;
        end else begin
          // z runs fastest, then y, then x.
          if (z_q == MAX_V) begin
            z_d = ZMIN;
            if (y_q == MAX_V) begin
              y_d = YMIN;
              x_d = x_q + 8'd1;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            z_d = z_q + 8'd1;
          end
          state_d = S_EVAL_XX;
        end
      end
      S_PRESENT, S_FAIL: begin
        if (bus.ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    valid_d  = (state_d == S_PRESENT) || (state_d == S_FAIL);
    no_sol_d = (state_d == S_FAIL);
    busy_d   = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      z_q      <= 8'd0;
      t1_q     <= 8'd0;
      t2_q     <= 8'd0;
      target_q <= 8'd0;
      sol_x_q  <= 8'd0;
      sol_y_q  <= 8'd0;
      sol_z_q  <= 8'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      no_sol_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      target_q <= target_d;
      sol_x_q  <= sol_x_d;
      sol_y_q  <= sol_y_d;
      sol_z_q  <= sol_z_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      no_sol_q <= no_sol_d;
    end
  end

  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.noSolution = no_sol_q;
  assign bus.solX       = sol_x_q;
  assign bus.solY       = sol_y_q;
  assign bus.solZ       = sol_z_q;
  assign bus.target     = target_q;

endmodule
